// File: rtl/window_linebuffer_if.sv
// Pixel-stream input and flat-window output bundle for window_linebuffer.
// The slave side is the line buffer; the master side is the pixel producer / window consumer.
interface window_linebuffer_if #(
    parameter int unsigned KSIZE = 9,
    parameter int unsigned PW    = 7
);
    logic                      in_valid;
    logic [PW-1:0]             in_data;
    logic                      in_sof;
    logic                      win_valid;
    logic [KSIZE*KSIZE*PW-1:0] win_data;
    logic [9:0]                win_row;
    logic [9:0]                win_col;
    logic                      frame_done;

    modport master (
        output in_valid, in_data, in_sof,
        input  win_valid, win_data, win_row, win_col, frame_done
    );

    modport slave (
        input  in_valid, in_data, in_sof,
        output win_valid, win_data, win_row, win_col, frame_done
    );
endinterface

// File: rtl/window_linebuffer.sv
// Raster-order line buffer producing every complete KSIZE x KSIZE window as a flat bus,
// one registered window per accepted pixel once the window lies fully inside the frame.
module window_linebuffer #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned KSIZE = 9,
    parameter int unsigned PW    = 7
) (
    input logic                clk,
    input logic                rst,
    window_linebuffer_if.slave io_win
);
    localparam int unsigned CW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned DW      = KSIZE * KSIZE * PW;
    localparam logic [9:0]  LastCol = 10'(IMG_W - 1);
    localparam logic [9:0]  LastRow = 10'(IMG_H - 1);
    localparam logic [9:0]  KMinus1 = 10'(KSIZE - 1);

    logic          w_acc;
    logic          w_sof;
    logic [9:0]    r_row;
    logic [9:0]    r_col;
    logic [9:0]    w_row;
    logic [9:0]    w_col;
    logic [9:0]    w_row_nxt;
    logic [9:0]    w_col_nxt;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_win_ok;
    logic [CW-1:0] w_idx;

    logic [PW-1:0] r_lb      [KSIZE-1][IMG_W];
    logic [PW-1:0] w_lb_rd   [KSIZE-1];
    logic [PW-1:0] r_win     [KSIZE][KSIZE];
    logic [PW-1:0] w_win_nxt [KSIZE][KSIZE];
    logic [DW-1:0] w_win_flat;

    logic          r_win_valid;
    logic          r_frame_done;
    logic [DW-1:0] r_win_data;
    logic [9:0]    r_win_row;
    logic [9:0]    r_win_col;

    // A qualified start-of-frame overrides the running position for this pixel only.
    assign w_acc      = io_win.in_valid;
    assign w_sof      = io_win.in_valid & io_win.in_sof;
    assign w_row      = w_sof ? '0 : r_row;
    assign w_col      = w_sof ? '0 : r_col;
    assign w_idx      = w_col[CW-1:0];
    assign w_last_col = (w_col == LastCol);
    assign w_last_row = (w_row == LastRow);
    assign w_win_ok   = (w_row >= KMinus1) && (w_col >= KMinus1);

    always_comb begin
        w_row_nxt = w_row;
        w_col_nxt = w_col + 10'd1;
        if (w_last_col) begin
            w_col_nxt = '0;
            w_row_nxt = w_last_row ? '0 : w_row + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_acc) begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
        end
    end

    // Buffer k at column c holds pixel(r-1-k, c); reads see the pre-write contents.
    always_comb begin
        for (int k = 0; k < int'(KSIZE) - 1; k++) begin
            w_lb_rd[k] = r_lb[k][w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb[0][w_idx] <= io_win.in_data;
            for (int k = 1; k < int'(KSIZE) - 1; k++) begin
                r_lb[k][w_idx] <= w_lb_rd[k-1];
            end
        end
    end

    // Shift left; new right column is oldest buffered row at top, incoming pixel at bottom.
    always_comb begin
        for (int i = 0; i < int'(KSIZE); i++) begin
            for (int j = 0; j < int'(KSIZE) - 1; j++) begin
                w_win_nxt[i][j] = r_win[i][j+1];
            end
        end
        for (int i = 0; i < int'(KSIZE) - 1; i++) begin
            w_win_nxt[i][KSIZE-1] = w_lb_rd[int'(KSIZE) - 2 - i];
        end
        w_win_nxt[KSIZE-1][KSIZE-1] = io_win.in_data;
    end

    always_comb begin
        w_win_flat = '0;
        for (int i = 0; i < int'(KSIZE); i++) begin
            for (int j = 0; j < int'(KSIZE); j++) begin
                w_win_flat[PW*(int'(KSIZE)*i+j) +: PW] = w_win_nxt[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_win <= w_win_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_data   <= '0;
            r_win_row    <= '0;
            r_win_col    <= '0;
        end else begin
            r_win_valid  <= w_acc & w_win_ok;
            r_frame_done <= w_acc & w_last_row & w_last_col;
            if (w_acc && w_win_ok) begin
                r_win_data <= w_win_flat;
                r_win_row  <= w_row - KMinus1;
                r_win_col  <= w_col - KMinus1;
            end
        end
    end

    assign io_win.win_valid  = r_win_valid;
    assign io_win.frame_done = r_frame_done;
    assign io_win.win_data   = r_win_data;
    assign io_win.win_row    = r_win_row;
    assign io_win.win_col    = r_win_col;
endmodule

// File: tb/tb_window_linebuffer.sv
// Scoreboard bench for window_linebuffer: the driver pushes expected windows and frame_done
// pulses with their due cycle, a negedge monitor pops and compares whatever the DUT presents.
module tb_window_linebuffer;
    localparam int W  = 28;
    localparam int H  = 28;
    localparam int K  = 9;
    localparam int PW = 7;
    localparam int DW = K * K * PW;

    typedef struct packed {
        int          stamp;
        logic [9:0]  row;
        logic [9:0]  col;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_linebuffer_if #(.KSIZE(K), .PW(PW)) bus ();

    window_linebuffer #(
        .IMG_W (W),
        .IMG_H (H),
        .KSIZE (K),
        .PW    (PW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_win (bus)
    );

    exp_t          q[$];
    int            fdq[$];
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            n_win = 0;
    int            n_fd = 0;
    int            mr = 0;
    int            mc = 0;
    logic [PW-1:0] pix [H][W];
    logic [DW-1:0] first_win = '0;
    logic [DW-1:0] row1_win = '0;
    logic [DW-1:0] all7f;
    exp_t          m_e;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec = n_vec + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic logic [PW-1:0] el(input logic [DW-1:0] x, input int e);
        return x[PW*e +: PW];
    endfunction

    task automatic send(input logic [PW-1:0] d, input logic sof);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        pix[mr][mc] = d;
        if (mr >= K - 1 && mc >= K - 1) begin
            e.stamp = cyc + 1;
            e.row   = 10'(mr - K + 1);
            e.col   = 10'(mc - K + 1);
            e.data  = '0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    e.data[PW*(K*i+j) +: PW] = pix[mr-K+1+i][mc-K+1+j];
                end
            end
            q.push_back(e);
        end
        if (mr == H - 1 && mc == W - 1) fdq.push_back(cyc + 1);
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
            bus.in_data  = PW'($urandom);
        end
    endtask

    // kind 0: ramp (28r+c) mod 128; kind 1: constant 0x7F. gap_pct: chance of idle before a pixel.
    task automatic frame(input int kind, input int gap_pct, input bit sof0, input int npix);
        for (int p = 0; p < npix; p++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1 + $urandom_range(0, 2));
            send((kind == 0) ? PW'((28 * (p / W) + (p % W)) % 128) : 7'h7f, sof0 && p == 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() > 0 && q[0].stamp < cyc) begin
                m_e = q.pop_front();
                n_vec = n_vec + 1;
                n_err = n_err + 1;
                $display("FAIL window r%0d c%0d: win_valid=0, expected 1", m_e.row, m_e.col);
            end
            if (q.size() > 0 && q[0].stamp == cyc) begin
                m_e = q.pop_front();
                n_vec = n_vec + 1;
                if (!bus.win_valid || bus.win_row !== m_e.row || bus.win_col !== m_e.col ||
                    bus.win_data !== m_e.data) begin
                    n_err = n_err + 1;
                    $display("FAIL window r%0d c%0d: got v=%0b r%0d c%0d data=%0h, expected data=%0h",
                             m_e.row, m_e.col, bus.win_valid, bus.win_row, bus.win_col,
                             bus.win_data, m_e.data);
                end else begin
                    if (m_e.row == 0 && m_e.col == 0) first_win = bus.win_data;
                    if (m_e.row == 1 && m_e.col == 0) row1_win = bus.win_data;
                end
            end else if (bus.win_valid) begin
                n_vec = n_vec + 1;
                n_err = n_err + 1;
                $display("FAIL unexpected win_valid: got 1 at r%0d c%0d, expected 0",
                         bus.win_row, bus.win_col);
            end
            if (bus.win_valid) n_win = n_win + 1;

            while (fdq.size() > 0 && fdq[0] < cyc) begin
                void'(fdq.pop_front());
                chk("frame_done missing", 64'(0), 64'(1));
            end
            if (fdq.size() > 0 && fdq[0] == cyc) begin
                void'(fdq.pop_front());
                chk("frame_done", 64'(bus.frame_done), 64'(1));
            end else if (bus.frame_done) begin
                chk("frame_done unexpected", 64'(1), 64'(0));
            end
            if (bus.frame_done) n_fd = n_fd + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int e = 0; e < K * K; e++) all7f[PW*e +: PW] = 7'h7f;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sof   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset win_valid", 64'(bus.win_valid), 64'(0));
        chk("reset frame_done", 64'(bus.frame_done), 64'(0));
        chk("reset win_data", 64'(bus.win_data != '0), 64'(0));
        chk("reset win_row", 64'(bus.win_row), 64'(0));
        chk("reset win_col", 64'(bus.win_col), 64'(0));
        rst = 1'b0;

        // Ramp frame, continuous valid
        n_win = 0; n_fd = 0;
        frame(0, 0, 1'b1, W * H);
        idle(3);
        chk("ramp window count", 64'(n_win), 64'(400));
        chk("ramp frame_done count", 64'(n_fd), 64'(1));
        chk("first window e0", 64'(el(first_win, 0)), 64'(0));
        chk("first window e8", 64'(el(first_win, 8)), 64'(8));
        chk("first window e72", 64'(el(first_win, 72)), 64'(96));
        chk("first window e80", 64'(el(first_win, 80)), 64'(104));
        chk("row1 col0 window e80", 64'(el(row1_win, 80)), 64'(4));

        // Same frame with ~50% idle gaps
        n_win = 0; n_fd = 0;
        frame(0, 50, 1'b1, W * H);
        idle(3);
        chk("gapped window count", 64'(n_win), 64'(400));
        chk("gapped frame_done count", 64'(n_fd), 64'(1));

        // Back-to-back ramp then constant frame
        n_win = 0; n_fd = 0;
        frame(0, 0, 1'b1, W * H);
        frame(1, 0, 1'b1, W * H);
        idle(3);
        chk("b2b window count", 64'(n_win), 64'(800));
        chk("b2b frame_done count", 64'(n_fd), 64'(2));
        chk("const frame held window", 64'(bus.win_data != all7f), 64'(0));

        // Abort after 100 pixels with a fresh start-of-frame
        n_win = 0; n_fd = 0;
        frame(0, 0, 1'b1, 100);
        frame(0, 0, 1'b1, W * H);
        idle(3);
        chk("sof abort window count", 64'(n_win), 64'(400));
        chk("sof abort frame_done count", 64'(n_fd), 64'(1));

        // Asynchronous reset mid-frame, then a frame without start-of-frame
        frame(0, 0, 1'b1, 300);
        idle(1);
        chk("pre-reset window nonzero", 64'(bus.win_data != '0), 64'(1));
        #3 rst = 1'b1;
        #1;
        chk("async rst win_valid", 64'(bus.win_valid), 64'(0));
        chk("async rst win_data", 64'(bus.win_data != '0), 64'(0));
        chk("async rst win_row", 64'(bus.win_row), 64'(0));
        chk("async rst win_col", 64'(bus.win_col), 64'(0));
        chk("async rst frame_done", 64'(bus.frame_done), 64'(0));
        q.delete();
        fdq.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        mr = 0; mc = 0;
        n_win = 0; n_fd = 0;
        frame(0, 0, 1'b0, W * H);
        idle(3);
        chk("post-reset window count", 64'(n_win), 64'(400));
        chk("post-reset frame_done count", 64'(n_fd), 64'(1));

        chk("scoreboard windows drained", 64'(q.size()), 64'(0));
        chk("scoreboard frame_done drained", 64'(fdq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/window_linebuffer.md
Name: window_linebuffer

Overview:
- Streaming producer for the logistic-regression inner-product stage.
- Accepts a raster-order pixel stream (7-bit grey pixels) and keeps KSIZE-1 line buffers plus a KSIZE x KSIZE window register.
- Presents every complete KSIZE x KSIZE window as a flat bus, one window per accepted pixel once the window is fully inside the frame.
- Default 9x9 = 81 elements, feeding the 81-entry x-vector input of the innerproduct stage.

Parameters:
- IMG_W, 28: frame width in pixels; range KSIZE..1024.
- IMG_H, 28: frame height in pixels; range KSIZE..1024.
- KSIZE, 9: window side length.
- PW, 7: pixel width in bits.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  pixel present this cycle.
- in_data  input  PW  pixel value.
- in_sof  input  1  start of frame; qualified by in_valid.
- win_valid  output  1  win_data holds a complete window (one-cycle pulse per window).
- win_data  output  KSIZE*KSIZE*PW  window; element e=KSIZE*i+j at bits [PW*e+PW-1 : PW*e].
- win_row  output  10  frame row of window top-left pixel.
- win_col  output  10  frame column of window top-left pixel.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (async assert, sync release): win_valid=0, frame_done=0, win_data=0, win_row=0, win_col=0; row/col counters=0.
  - Line-buffer and window contents need no reset; they are never exposed before win_valid.
- No backpressure. The block accepts every cycle in which in_valid=1; gaps of any length are allowed and state holds while in_valid=0.
- Pixel position:
  - Counters (r,c) give the position of the pixel being accepted.
  - After acceptance, c increments; at c=IMG_W-1, c wraps to 0 and r increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and frame_done pulses on the next cycle.
- in_sof with in_valid forces that pixel to position (0,0), regardless of the counters; subsequent counting proceeds from there.
  - in_sof on an already-(0,0) pixel has no extra effect.
  - in_sof without in_valid is ignored.
- Line buffers:
  - KSIZE-1 buffers, each IMG_W deep, cascaded, indexed by c.
  - On acceptance, buffer k read at c yields pixel(r-1-k, c), and the cascade is written so the next row sees the updated history.
  - Read and write at the same index in the same cycle returns old data (read-before-write).
  - RAM or shift-register implementation is free, but must meet this behaviour.
- Window register:
  - On acceptance, all columns shift left by one.
  - The new rightmost column is {pixel(r-KSIZE+1,c) .. pixel(r-1,c), in_data}, with top = oldest row.
- Output:
  - Registered; latency 1 cycle from acceptance of pixel (r,c).
  - If r>=KSIZE-1 and c>=KSIZE-1, then on the next cycle:
    - win_valid=1
    - element(i,j) = pixel(r-KSIZE+1+i, c-KSIZE+1+j)
    - win_row=r-KSIZE+1, win_col=c-KSIZE+1
  - Otherwise win_valid=0.
  - win_data/row/col hold their last value while win_valid=0.
- Windows never straddle a row boundary; stale columns from the previous row are masked by the c>=KSIZE-1 condition.
- Windows per frame: (IMG_H-KSIZE+1)*(IMG_W-KSIZE+1).
- Simultaneous last pixel of frame and in_sof on the following pixel: the frame_done pulse and the new frame proceed independently.
- Frame-to-frame: line-buffer contents from the previous frame may remain. They are never output, because rows 0..KSIZE-2 produce no window.
- Reset mid-frame: counters return to (0,0) immediately and outputs clear; the next accepted pixel is (0,0).

Test Plan:
- Ramp frame, IMG_W=IMG_H=28, pixel(r,c)=(28r+c) mod 128, continuous valid:
  - first win_valid one cycle after accepting (8,8), with win_row=0, win_col=0;
  - element0=0, element8=8, element72=(28*8) mod 128=96, element80=104;
  - exactly 400 win_valid pulses, and frame_done once, one cycle after (27,27).
- Same frame with random in_valid gaps (about 50% duty) -> identical window sequence, coordinates and count; no win_valid during gaps.
- Row transition: after the window at (r=8, c=27), the next window is at win_row=1, win_col=0, with element80=pixel(9,8), and no window is produced for c=0..7 of row 9.
- Two back-to-back frames, the second a constant 0x7F: every window of frame 2 is all 0x7F, with no frame-1 data leaking.
- in_sof asserted at pixel index 100 of frame 1: counting restarts at (0,0); the first window appears one cycle after the 9th pixel of row 8 of the new frame; no frame_done from the aborted frame.
- rst pulse mid-frame (asynchronous, between clock edges): outputs go to 0 without a clock edge; after release, a full ramp frame produces the correct 400 windows.
